// File: rtl/verdict_pkg.sv
// rtl/verdict_pkg.sv - shared record type and default sizes for the verdict collector
package verdict_pkg;

  localparam int NUM_OUT_DEF = 4;
  localparam int DATA_W_DEF  = 64;
  localparam int TS_W_DEF    = 32;
  localparam int DEPTH_DEF   = 16;

  // Field order is the bit order the collector stores and presents on rec_*
  typedef struct packed {
    logic [TS_W_DEF-1:0]               ts;
    logic [NUM_OUT_DEF-1:0]            mask;
    logic [NUM_OUT_DEF*DATA_W_DEF-1:0] data;
  } verdict_rec_t;

endpackage

// File: rtl/verdict_collector_sync_fifo.sv
// rtl/verdict_collector_sync_fifo.sv - single-clock FIFO with registered head output
// A push while full is accepted only if a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic             wr;
  logic             rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd      = pop && !empty;
  assign wr      = push && (!full || rd);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  // dout mirrors mem[rd_ptr]; when the head would come from a slot written
  // this same edge, it is taken straight from din instead
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_next;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && (empty || (rd && count == (AW+1)'(1)))) begin
        dout <= din;
      end else if (rd && count > (AW+1)'(1)) begin
        dout <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/verdict_collector.sv
// rtl/verdict_collector.sv - timestamps active monitor outputs and queues them as records
// Optional saturating drop counter enabled by VERDICT_COLLECTOR_DROP_CNT_EN.
module verdict_collector
  import verdict_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TS_W    = TS_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [TS_W-1:0]           rec_ts,
  output logic [NUM_OUT-1:0]        rec_mask,
  output logic [NUM_OUT*DATA_W-1:0] rec_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [15:0]               drop_cnt
);

  localparam int REC_W = TS_W + NUM_OUT + NUM_OUT*DATA_W;

  logic [TS_W-1:0]  ts;
  logic [REC_W-1:0] rec;
  logic             capture;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;

  assign capture   = en && |out_aktv;
  assign rec_valid = !empty;
  assign pop       = rec_valid && rec_ready;
  assign drop      = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (rst)     ts <= '0;
    else if (en) ts <= ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
  end
`else
  assign drop_cnt = '0;
`endif

  // Record layout matches verdict_rec_t: {ts, mask, data}
  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .din   ({ts, out_aktv, out_data}),
    .dout  (rec),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign {rec_ts, rec_mask, rec_data} = rec;

endmodule

// File: tb/tb_verdict_collector.sv
// tb/tb_verdict_collector.sv - scoreboard and vector-table bench for verdict_collector
module tb_verdict_collector;
  import verdict_pkg::*;

  localparam int NO = 4, DW = 64, TW = 32, DEP = 16;
  localparam logic [15:0] EXP_DROP =
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    16'd4;
`else
    16'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, rec_ready, rec_valid, overflow;
  logic [NO*DW-1:0]  out_data, rec_data;
  logic [NO-1:0]     out_aktv, rec_mask;
  logic [TW-1:0]     rec_ts;
  logic [4:0]        level;
  logic [15:0]       drop_cnt;

  logic              en_w, ready_w, valid_w, ovf_w;
  logic [31:0]       data_w, rdata_w;
  logic [3:0]        aktv_w, mask_w, rts_w;
  logic [2:0]        level_w;
  logic [15:0]       drop_w;

  verdict_collector dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts), .rec_mask(rec_mask),
    .rec_data(rec_data), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  verdict_collector #(.NUM_OUT(4), .DATA_W(8), .TS_W(4), .DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .en(en_w), .out_data(data_w), .out_aktv(aktv_w),
    .rec_valid(valid_w), .rec_ready(ready_w), .rec_ts(rts_w), .rec_mask(mask_w),
    .rec_data(rdata_w), .level(level_w), .overflow(ovf_w), .drop_cnt(drop_w)
  );

  typedef struct {
    logic       en;
    logic [3:0] aktv;
    logic       ready;
    int         exp_level;
  } vec_t;

  verdict_rec_t q[$];
  logic [31:0]  m_ts;
  logic         m_ovf;
  logic [15:0]  m_drop;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Samples at negedge, updates the reference model, returns 1 time unit after the next posedge
  task automatic cycle();
    verdict_rec_t r;
    @(negedge clk);
    if (rst) begin
      q.delete();
      m_ts = '0; m_ovf = 1'b0; m_drop = '0;
    end else begin
      chk("rec_valid", rec_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (q.size() != 0 && rec_ready) begin
        r = q.pop_front();
        chk("pop_ts", rec_ts, r.ts);
        chk("pop_mask", rec_mask, r.mask);
        chk("pop_data", rec_data, r.data);
      end
      if (en && |out_aktv) begin
        if (q.size() < DEP) begin
          r.ts = m_ts; r.mask = out_aktv; r.data = out_data;
          q.push_back(r);
        end else begin
          m_ovf = 1'b1;
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
          if (m_drop != 16'hFFFF) m_drop++;
`endif
        end
      end
      if (en) m_ts++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] k, t;
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'b0001, 1'b0, 1};
    tbl[2]  = '{1'b1, 4'b1111, 1'b0, 2};
    tbl[3]  = '{1'b1, 4'b0010, 1'b1, 2};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 2};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1};
    tbl[6]  = '{1'b1, 4'b1000, 1'b1, 1};
    tbl[7]  = '{1'b1, 4'b0000, 1'b1, 0};
    tbl[8]  = '{1'b1, 4'b0000, 1'b1, 0};
    tbl[9]  = '{1'b1, 4'b0100, 1'b1, 1};
    tbl[10] = '{1'b1, 4'b0011, 1'b1, 1};
    tbl[11] = '{1'b1, 4'b0000, 1'b1, 0};

    rst = 1'b1; en = 1'b0; rec_ready = 1'b0; out_aktv = '0; out_data = '0;
    en_w = 1'b0; ready_w = 1'b0; aktv_w = '0; data_w = '0;
    cycle(); cycle();
    rst = 1'b0;
    chk("reset_rec_ts", rec_ts, 0);
    chk("reset_rec_mask", rec_mask, 0);
    chk("reset_rec_data", rec_data, 0);

    // 100 idle cycles; ts ends at 50
    en = 1'b1;
    for (int i = 0; i < 50; i++) cycle();
    en = 1'b0;
    for (int i = 0; i < 50; i++) cycle();

    en = 1'b1; out_aktv = 4'b0101;
    out_data = '0; out_data[0 +: 64] = 64'd1; out_data[128 +: 64] = 64'd3;
    cycle();
    out_aktv = '0;
    chk("single_valid", rec_valid, 1);
    chk("single_ts", rec_ts, 50);
    chk("single_mask", rec_mask, 4'b0101);
    chk("single_d0", rec_data[0 +: 64], 1);
    chk("single_d2", rec_data[128 +: 64], 3);
    rec_ready = 1'b1;
    cycle();
    chk("single_level", level, 0);

    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; out_aktv = tbl[i].aktv; rec_ready = tbl[i].ready;
      out_data = rand_data();
      cycle();
      chk("tbl_level", level, tbl[i].exp_level);
    end

    // Burst of 20 into a 16-deep FIFO
    en = 1'b1; rec_ready = 1'b0; k = m_ts;
    for (int i = 0; i < 20; i++) begin
      out_aktv = 4'($urandom_range(1, 15)); out_data = rand_data();
      cycle();
    end
    chk("burst_level", level, 16);
    chk("burst_overflow", overflow, 1);
    chk("burst_drop", drop_cnt, EXP_DROP);
    chk("burst_head_ts", rec_ts, k);
    out_aktv = 4'b0001; out_data = rand_data(); rec_ready = 1'b1;
    cycle();
    chk("fullpop_level", level, 16);
    chk("fullpop_drop", drop_cnt, EXP_DROP);
    en = 1'b0; out_aktv = '0;
    for (int j = 0; j < 16; j++) begin
      chk("drain_ts", rec_ts, (j < 15) ? k + 1 + j : k + 20);
      cycle();
    end
    chk("drain_level", level, 0);

    // Enable gap between two captures
    en = 1'b1; rec_ready = 1'b0; out_aktv = 4'b0010; out_data = rand_data(); t = m_ts;
    cycle();
    en = 1'b0; out_aktv = 4'b1111;
    for (int i = 0; i < 10; i++) cycle();
    en = 1'b1; out_aktv = 4'b0100; out_data = rand_data();
    cycle();
    en = 1'b0; out_aktv = '0; rec_ready = 1'b1;
    chk("gap_ts0", rec_ts, t);
    cycle();
    chk("gap_ts1", rec_ts, t + 1);
    cycle();
    chk("gap_level", level, 0);

    // Reset with five pending records
    en = 1'b1; rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_aktv = 4'($urandom_range(1, 15)); out_data = rand_data();
      cycle();
    end
    chk("prereset_level", level, 5);
    rst = 1'b1; out_aktv = 4'b1111; rec_ready = 1'b1;
    cycle();
    rst = 1'b0; en = 1'b0; out_aktv = '0; rec_ready = 1'b0;
    chk("midreset_level", level, 0);
    chk("midreset_valid", rec_valid, 0);
    chk("midreset_overflow", overflow, 0);
    chk("midreset_drop", drop_cnt, 0);
    cycle();

    // Timestamp wrap on the 4-bit instance
    en_w = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    aktv_w = 4'b0001; data_w = $urandom;
    cycle();
    aktv_w = 4'b0010; data_w = $urandom;
    cycle();
    en_w = 1'b0; aktv_w = '0;
    chk("wrap_level", level_w, 2);
    chk("wrap_ts15", rts_w, 15);
    chk("wrap_mask0", mask_w, 4'b0001);
    ready_w = 1'b1;
    cycle();
    chk("wrap_ts0", rts_w, 0);
    chk("wrap_mask1", mask_w, 4'b0010);
    cycle();
    chk("wrap_drained", level_w, 0);
    ready_w = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/verdict_collector.md
# verdict_collector

Downstream capture stage for the generated RTLola monitor (`topEntity`). It samples the monitor's output streams and their `_aktv` flags every clock. On any cycle with at least one active output, it stores one timestamped verdict record in an internal FIFO. A downstream logger or host interface drains the records over a valid/ready stream, so the bench or SoC no longer polls the monitor's outputs directly.

## Interface
Parameters:
- `NUM_OUT`, 4: number of monitor output streams
- `DATA_W`, 64: width of each signed output value
- `TS_W`, 32: timestamp counter width
- `DEPTH`, 16: FIFO depth in records; power of two, ≥ 2

Ports:
- `clk`  in  1  system clock (same clock as `topEntity`)
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global enable, shared with the monitor
- `out_data`  in  NUM_OUT*DATA_W  concatenated `output_0`…`output_{N-1}`; stream i occupies bits [i*DATA_W +: DATA_W]
- `out_aktv`  in  NUM_OUT  `output_i_aktv` flags; bit i belongs to stream i
- `rec_valid`  out  1  head record available
- `rec_ready`  in  1  consumer accepts the head record
- `rec_ts`  out  TS_W  timestamp of the head record
- `rec_mask`  out  NUM_OUT  active mask of the head record
- `rec_data`  out  NUM_OUT*DATA_W  output values of the head record
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `overflow`  out  1  sticky flag: at least one record was dropped
- `drop_cnt`  out  16  number of dropped records; see Configuration

## Operation
- Timestamp counter `ts`:
  - Increments on every cycle with `en`=1; holds when `en`=0.
  - Wraps from 2^TS_W−1 to 0 with no flag.
- Capture condition: `en` && |`out_aktv`.
- Record contents: {`ts`, `out_aktv`, `out_data`}, using the current-cycle `ts` value, before its increment.
- Inactive streams are recorded as-is; their data fields are don't-care, and the consumer must qualify them with the mask.
- Pop: occurs when `rec_valid` && `rec_ready`.
- Push/pop resolution per cycle:
  - Not full: a capture always writes.
  - Full, no pop this cycle: the capture is dropped, `overflow` is set, and `drop_cnt` increments (saturating).
  - Full, pop this cycle: the capture is written and `level` stays at DEPTH.
  - Empty: no pop is possible (`rec_valid`=0). A simultaneous capture writes and `level` becomes 1.
- `en`=0: no captures. Pops remain allowed, so the FIFO can be drained while the monitor is frozen.
- `overflow` clears only on `rst`.

## Timing
- Capture latency:
  - A record captured at edge k shows `rec_valid`=1 after edge k; it is poppable in cycle k+1.
  - There is no combinational path from `out_*` to `rec_*`.
- Back-to-back captures every cycle are sustained at 1 record/cycle.
- `rec_*` outputs hold stable while `rec_valid`=1 && `rec_ready`=0.
- `level` updates at the same edge as the push or pop.
- Reset values:
  - `rec_valid`=0, `rec_ts`=0, `rec_mask`=0, `rec_data`=0
  - `level`=0, `overflow`=0, `drop_cnt`=0
  - internal `ts`=0
- Reset mid-operation: the FIFO is flushed, and pending records are discarded without being popped.
- Reset dominates `en` and any push or pop in the same cycle.

## Configuration
Macro: `VERDICT_COLLECTOR_DROP_CNT_EN`
- Defined: `drop_cnt` is a 16-bit counter of dropped records. It saturates at 0xFFFF.
- Undefined: there is no counter logic and `drop_cnt` is tied to 0. `overflow` is still implemented.

## Structure
- Package `verdict_pkg` holds:
  - `verdict_rec_t`, a packed struct {ts, mask, data}
  - default constants `NUM_OUT_DEF`, `DATA_W_DEF`, `TS_W_DEF`, `DEPTH_DEF`
- Sub-module `sync_fifo`:
  - Single-clock, parameterised width and depth.
  - Registered outputs, read-before-write on simultaneous full push and pop.
  - Exposes `full`, `empty`, `level`.
- The top level holds the timestamp counter, capture logic, and overflow/drop accounting.

## Test plan
- Reset release, no activity → `rec_valid`=0, `level`=0, `overflow`=0 for 100 cycles.
- Single capture:
  - Stimulus: `out_aktv`=4'b0101, output_0=1, output_2=3, at `ts`=50.
  - Required response: next cycle `rec_valid`=1, `rec_ts`=50, `rec_mask`=0101, matching data; pop on `rec_ready`=1 → `level`=0.
- Burst of 20 captures on consecutive cycles with `rec_ready`=0, DEPTH=16:
  - `level`=16, `overflow`=1, `drop_cnt`=4 (macro defined) or 0 (undefined).
  - Draining returns `ts` values k…k+15 in order.
- Full FIFO with simultaneous capture and pop → `level` stays 16, no drop, and the new record appears last.
- `en`=0 for 10 cycles between captures → `rec_ts` values differ by the number of enabled cycles only; draining works while `en`=0.
- Wrap and mid-operation reset:
  - TS_W=4: a capture at `ts`=15 followed by one a cycle later records `ts`=0.
  - `rst` asserted with `level`=5 → next cycle `level`=0 and `rec_valid`=0.
